// File: rtl/display_arbiter.sv
// display_arbiter: shares a 4-digit 7-segment display between a live background
// frame and two timed overlay sources, scanning digits and driving the anodes
// and segments directly.
// Optional feature macro: OVERLAY_BLINK_EN (blanks the display while an overlay
// is shown and hold-timer bit BLINK_BIT is set).
module display_arbiter #(
    parameter int unsigned SCAN_DIV    = 200000,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned BLINK_BIT   = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] bg_frame,
    input  logic        ov1_req,
    input  logic [27:0] ov1_frame,
    input  logic        ov2_req,
    input  logic [27:0] ov2_frame,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [2:0]  grant,
    output logic        busy
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef OVERLAY_BLINK_EN
    localparam int unsigned TIMER_W = (HOLD_W > BLINK_BIT) ? HOLD_W : BLINK_BIT + 1;
`else
    localparam int unsigned TIMER_W = HOLD_W;
`endif
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW1 = 2'd1,
        SHOW2 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [27:0]         f1_q, f1_d;
    logic [27:0]         f2_q, f2_d;
    logic                pend2_q, pend2_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [1:0]          digit_q, digit_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [2:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [27:0]         src_frame;

    // Scan divider: advance the digit index once per SCAN_DIV cycles
    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = digit_q + 2'd1;
        end
    end

    // Scan counter and digit index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            digit_q <= 2'd0;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
        end
    end

    // FSM state register, hold timer, pending flag and latched overlay frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            f1_q    <= '1;
            f2_q    <= '1;
            pend2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            pend2_q <= pend2_d;
        end
    end

    // Next-state logic: overlay priority, pending ov2, retrigger and expiry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        pend2_d = pend2_q;
        case (state_q)
            IDLE: begin
                if (ov1_req) begin
                    state_d = SHOW1;
                    f1_d    = ov1_frame;
                    timer_d = HOLD_LOAD;
                    if (ov2_req) begin
                        f2_d    = ov2_frame;
                        pend2_d = 1'b1;
                    end
                end else if (ov2_req) begin
                    state_d = SHOW2;
                    f2_d    = ov2_frame;
                    timer_d = HOLD_LOAD;
                end
            end
            SHOW1: begin
                if (ov2_req) begin
                    f2_d    = ov2_frame;
                    pend2_d = 1'b1;
                end
                if (ov1_req) begin
                    f1_d    = ov1_frame;
                    timer_d = HOLD_LOAD;
                end else if (timer_q == '0) begin
                    // An ov2 request in the expiry cycle counts as pending
                    if (pend2_q || ov2_req) begin
                        state_d = SHOW2;
                        pend2_d = 1'b0;
                        timer_d = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            SHOW2: begin
                if (ov1_req) begin
                    // Preemption drops the running ov2; only a fresh one is kept
                    state_d = SHOW1;
                    f1_d    = ov1_frame;
                    timer_d = HOLD_LOAD;
                    pend2_d = ov2_req;
                    if (ov2_req) begin
                        f2_d = ov2_frame;
                    end
                end else if (ov2_req) begin
                    f2_d    = ov2_frame;
                    timer_d = HOLD_LOAD;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pend2_d = 1'b0;
            end
        endcase
    end

    // Output logic: grant/busy track the next state, an/seg show the current source
    always_comb begin
        grant_d = 3'b001;
        busy_d  = 1'b0;
        case (state_d)
            SHOW1: begin
                grant_d = 3'b010;
                busy_d  = 1'b1;
            end
            SHOW2: begin
                grant_d = 3'b100;
                busy_d  = 1'b1;
            end
            default: begin
                grant_d = 3'b001;
                busy_d  = 1'b0;
            end
        endcase

        case (state_q)
            SHOW1:   src_frame = f1_q;
            SHOW2:   src_frame = f2_q;
            default: src_frame = bg_frame;
        endcase

        an_d = ~(4'b0001 << digit_q);
        case (digit_q)
            2'd0:    seg_d = src_frame[6:0];
            2'd1:    seg_d = src_frame[13:7];
            2'd2:    seg_d = src_frame[20:14];
            default: seg_d = src_frame[27:21];
        endcase

`ifdef OVERLAY_BLINK_EN
        if ((state_q != IDLE) && timer_q[BLINK_BIT]) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
`endif
    end

    // Registered display and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            grant_q <= 3'b001;
            busy_q  <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed bench for display_arbiter with SCAN_DIV=4 and
// HOLD_CYCLES=20; outputs are sampled 1 ns after each rising clock edge.
module tb_display_arbiter;

    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned HOLD_CYCLES = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [27:0] bg_frame;
    logic        ov1_req;
    logic [27:0] ov1_frame;
    logic        ov2_req;
    logic [27:0] ov2_frame;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [2:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Hand-computed anode walk and slices of bg_frame = 28'h0FEDCBA
    logic [3:0] an_walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] bg_slc  [4] = '{7'h3A, 7'h39, 7'h7B, 7'h07};

    display_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_BIT   (22)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bg_frame  (bg_frame),
        .ov1_req   (ov1_req),
        .ov1_frame (ov1_frame),
        .ov2_req   (ov2_req),
        .ov2_frame (ov2_frame),
        .an        (an),
        .seg       (seg),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_digit(input int c);
        return ((c - 1) / int'(SCAN_DIV)) % 4;
    endfunction

    function automatic logic [6:0] slice(input logic [27:0] f, input int d);
        return f[7*d +: 7];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic [27:0] frame);
        int         d;
        logic [3:0] ea;
        d  = exp_digit(cyc);
        ea = an_walk[d];
        check({tag, "_an"},    32'(an),    32'(ea));
        check({tag, "_seg"},   32'(seg),   32'(slice(frame, d)));
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_busy"},  32'(busy),  32'(g != 3'b001));
    endtask

    task automatic hold(input string tag, input logic [2:0] g, input logic [27:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            expect_out(tag, g, frame);
        end
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_an"},    32'(an),    32'(4'b1111));
        check({tag, "_seg"},   32'(seg),   32'(7'b1111111));
        check({tag, "_grant"}, 32'(grant), 32'(3'b001));
        check({tag, "_busy"},  32'(busy),  32'(1'b0));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        ov1_req   = 1'b0;
        ov2_req   = 1'b0;
        ov1_frame = '0;
        ov2_frame = '0;
        bg_frame  = 28'h0FEDCBA;

        // Reset state
        #2 rst_n = 1'b0;
        #20;
        expect_reset("rst");
        release_reset();

        // Background scan with hand-computed digit slices
        for (int i = 0; i < 16; i++) begin
            step();
            check("scan_an",    32'(an),    32'(an_walk[i/4]));
            check("scan_seg",   32'(seg),   32'(bg_slc[i/4]));
            check("scan_grant", 32'(grant), 32'(3'b001));
            check("scan_busy",  32'(busy),  32'(1'b0));
        end

        // Single ov1 overlay; background change hidden while shown
        ov1_frame = 28'h1234567;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("b_enter", 3'b010, 28'h0FEDCBA);
        bg_frame = 28'h5555555;
        hold("b_hold", 3'b010, 28'h1234567, 19);
        step();
        expect_out("b_last", 3'b001, 28'h1234567);
        hold("b_resume", 3'b001, 28'h5555555, 2);

        // Simultaneous requests: ov1 first, then pending ov2
        ov1_frame = 28'hABCDEF0;
        ov2_frame = 28'h0F0F0F0;
        ov1_req   = 1'b1;
        ov2_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        ov2_req = 1'b0;
        expect_out("c_enter", 3'b010, 28'h5555555);
        hold("c_s1", 3'b010, 28'hABCDEF0, 19);
        step();
        expect_out("c_switch", 3'b100, 28'hABCDEF0);
        hold("c_s2", 3'b100, 28'h0F0F0F0, 19);
        step();
        expect_out("c_last", 3'b001, 28'h0F0F0F0);
        hold("c_idle", 3'b001, 28'h5555555, 2);

        // ov1 preempts SHOW2 at hold cycle 5; ov2 is not resumed
        ov2_frame = 28'h3C3C3C3;
        ov2_req   = 1'b1;
        step();
        ov2_req = 1'b0;
        expect_out("d_enter", 3'b100, 28'h5555555);
        hold("d_s2", 3'b100, 28'h3C3C3C3, 4);
        ov1_frame = 28'h2468ACE;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("d_preempt", 3'b010, 28'h3C3C3C3);
        hold("d_s1", 3'b010, 28'h2468ACE, 19);
        step();
        expect_out("d_last", 3'b001, 28'h2468ACE);
        hold("d_idle", 3'b001, 28'h5555555, 4);

        // Retrigger at hold cycle 15: 35 cycles busy in total
        ov1_frame = 28'h1111111;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("e_enter", 3'b010, 28'h5555555);
        hold("e_first", 3'b010, 28'h1111111, 14);
        ov1_frame = 28'h7777777;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("e_retrig", 3'b010, 28'h1111111);
        hold("e_second", 3'b010, 28'h7777777, 19);
        step();
        expect_out("e_last", 3'b001, 28'h7777777);
        hold("e_idle", 3'b001, 28'h5555555, 2);

        // Retrigger in the expiry cycle keeps SHOW1
        ov1_frame = 28'h0123456;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("x_enter", 3'b010, 28'h5555555);
        hold("x_first", 3'b010, 28'h0123456, 19);
        ov1_frame = 28'h6543210;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("x_expiry", 3'b010, 28'h0123456);
        hold("x_second", 3'b010, 28'h6543210, 19);
        step();
        expect_out("x_last", 3'b001, 28'h6543210);
        hold("x_idle", 3'b001, 28'h5555555, 2);

        // Asynchronous reset mid-SHOW2
        ov2_frame = 28'h1E1E1E1;
        ov2_req   = 1'b1;
        step();
        ov2_req = 1'b0;
        expect_out("f_enter", 3'b100, 28'h5555555);
        hold("f_s2", 3'b100, 28'h1E1E1E1, 5);
        #2 rst_n = 1'b0;
        #1;
        expect_reset("f_async");
        release_reset();
        hold("f_idle", 3'b001, 28'h5555555, 8);

        // Reset mid-SHOW1 with ov2 pending: pending is discarded
        ov1_frame = 28'h0AAAAAA;
        ov2_frame = 28'h0333333;
        ov1_req   = 1'b1;
        ov2_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        ov2_req = 1'b0;
        expect_out("g_enter", 3'b010, 28'h5555555);
        hold("g_s1", 3'b010, 28'h0AAAAAA, 3);
        #2 rst_n = 1'b0;
        #1;
        expect_reset("g_async");
        release_reset();
        hold("g_idle", 3'b001, 28'h5555555, 2);
        ov1_frame = 28'h4444444;
        ov1_req   = 1'b1;
        step();
        ov1_req = 1'b0;
        expect_out("g_reenter", 3'b010, 28'h5555555);
        hold("g_s1b", 3'b010, 28'h4444444, 19);
        step();
        expect_out("g_nopend", 3'b001, 28'h4444444);
        hold("g_end", 3'b001, 28'h5555555, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
Shares the 4-digit 7-segment display between three sources.
- The background source (current note name) is shown by default.
- Two overlay sources (e.g. volume, octave) pulse a request and take the display for a fixed hold time.
- Handles digit scanning, overlay priority, pending and retrigger, and drives the board anodes and segments directly.

Parameters:
SCAN_DIV, 200000, clk cycles per digit-scan step (~250 Hz at 50 MHz)
HOLD_CYCLES, 50000000, clk cycles an overlay stays on screen
BLINK_BIT, 22, hold-timer bit used for blinking (only with OVERLAY_BLINK_EN)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
bg_frame  in  28  background segment codes; digit d = bits [7d+6:7d], active-low segments
ov1_req  in  1  overlay-1 request, single-cycle pulse
ov1_frame  in  28  overlay-1 codes, sampled when ov1_req=1
ov2_req  in  1  overlay-2 request, single-cycle pulse
ov2_frame  in  28  overlay-2 codes, sampled when ov2_req=1
an  out  4  digit anodes, active-low
seg  out  7  segment cathodes, active-low
grant  out  3  one-hot current source: bit0 bg, bit1 ov1, bit2 ov2
busy  out  1  1 while an overlay is shown

Behaviour:
Clock and reset:
- Single clock clk; rst_n is asynchronous, active-low.
- While rst_n=0: an=4'b1111, seg=7'b1111111, grant=3'b001, busy=0. Internally, state=IDLE, digit=0, scan count=0, pend2=0, timer=0, latched frames=all 1s.
- Reset asserted mid-overlay aborts it immediately. There is no resume.

Scan:
- Counter runs 0..SCAN_DIV-1 and then wraps.
- On the wrap cycle, 2-bit digit increments; it wraps 3->0.

Output registers (an, seg):
- Updated every clk: an <= ~(4'b0001 << digit); seg <= selected frame digit slice.
- Latency is 1 clk from a change of digit or displayed source; an and seg always change in the same cycle.
- First clk after reset release: an=4'b1110, seg=bg_frame[6:0].

Source select:
- IDLE -> live bg_frame (not latched).
- SHOW1 -> latched f1.
- SHOW2 -> latched f2.

FSM (IDLE, SHOW1, SHOW2):
- IDLE: if ov1_req, latch f1, load timer=HOLD_CYCLES-1, go to SHOW1. ov1 wins a tie; a simultaneous ov2_req latches f2 and sets pend2. Else if ov2_req, latch f2, load timer, go to SHOW2.
- SHOW1: timer decrements each clk.
  - ov1_req relatches f1 and reloads the timer (retrigger).
  - ov2_req latches f2 and sets pend2; a newer ov2_req overwrites f2.
  - When timer=0 and there is no ov1_req: if pend2, clear pend2, reload the timer, go to SHOW2; else go to IDLE.
- SHOW2:
  - ov2_req relatches f2 and reloads the timer.
  - ov1_req preempts: latch f1, reload the timer, go to SHOW1. The interrupted ov2 is dropped and pend2 stays 0.
  - When timer=0 and there is no request, go to IDLE.
- Timing: each overlay entry occupies exactly HOLD_CYCLES clk in its state. grant and busy are registered and follow the state in the same cycle as the state register.
- Requests arriving in the expiry cycle take priority over expiry.

Optional Feature:
OVERLAY_BLINK_EN
- Defined: in SHOW1/SHOW2, whenever timer[BLINK_BIT]=1, the registered outputs are forced to an=4'b1111 and seg=7'b1111111. Scan and timer keep running. IDLE is unaffected.
- Undefined: no blanking; the BLINK_BIT parameter is unused.

Test Plan:
All scenarios use SCAN_DIV=4 and HOLD_CYCLES=20.
- Reset, then release with bg_frame=28'h0FEDCBA -> an walks 1110,1101,1011,0111, changing every 4 clk. seg matches the bg slice for each digit; grant=001, busy=0.
- Pulse ov1_req with ov1_frame=28'h1234567 -> next clk grant=010 and busy=1; seg shows f1 slices for exactly 20 clk, then grant=001 and the bg display resumes. A bg_frame change during the overlay is not shown.
- ov1_req and ov2_req in the same cycle -> SHOW1 for 20 clk, then SHOW2 for 20 clk showing f2, then IDLE. Total busy=1 for 40 clk.
- In SHOW2, pulse ov1_req at hold cycle 5 -> SHOW1 for 20 clk, then IDLE; ov2 is not resumed.
- In SHOW1, re-pulse ov1_req at cycle 15 with a new frame -> the new frame displays and busy stays 1 for 20 more clk (35 clk total). Separately, pulse ov1_req in the expiry cycle -> the state stays SHOW1.
- Drive rst_n low asynchronously mid-SHOW2 -> an=1111, seg=1111111, grant=001 immediately without a clk edge. After release, pend2=0 and the display is in IDLE.
